// File: rtl/hex_disp_pkg.sv
// rtl/hex_disp_pkg.sv - shared types, blank code and hex-to-segment decode for the display arbiter
package hex_disp_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'h7F;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

    // Active-low gfedcba; lowercase b and d keep 6/8 and 0/D distinct.
    function automatic seg_t hex_to_seg(input logic [3:0] nib);
        seg_t seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/hex_display_arbiter_rr_arbiter.sv
// rtl/hex_display_arbiter_rr_arbiter.sv - combinational round-robin pick from a start index, optionally skipping one requester
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IW      = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      start,
    input  logic               excl_en,
    input  logic [IW-1:0]      excl_idx,
    output logic               found,
    output logic [IW-1:0]      idx
);

    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            int c;
            c = int'(start) + i;
            if (c >= NUM_REQ) begin
                c = c - NUM_REQ;
            end
            if (!found && req[c] && !(excl_en && (c == int'(excl_idx)))) begin
                found = 1'b1;
                idx   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/hex_display_arbiter.sv
// rtl/hex_display_arbiter.sv - round-robin owner of a shared seven-segment bank with minimum hold time
// Optional build macro: HEX_ZERO_BLANK_EN (leading-zero blanking on the decoded digits).
module hex_display_arbiter
    import hex_disp_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int NUM_DIGITS  = 4,
    parameter int HOLD_CYCLES = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*4*NUM_DIGITS-1:0] value,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          owner_valid,
    output logic [$clog2(NUM_REQ)-1:0]    owner_id,
    output logic [NUM_DIGITS*7-1:0]       hex_out
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int DW = 4 * NUM_DIGITS;
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] HOLD_MAX = CW'(HOLD_CYCLES - 1);
    localparam logic [IW-1:0] LAST_REQ = IW'(NUM_REQ - 1);

    arb_state_e    state, state_nx;
    logic [IW-1:0] owner_q, owner_nx;
    logic [IW-1:0] rr_ptr, rr_ptr_nx;
    logic [CW-1:0] hold_cnt, hold_cnt_nx;
    logic [DW-1:0] disp_reg, disp_nx;
    logic          shown, shown_nx;

    logic [IW-1:0] owner_succ;
    logic [IW-1:0] scan_start;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          owner_req;
    logic          hold_done;

    assign owner_succ = (owner_q == LAST_REQ) ? '0 : owner_q + IW'(1);
    // While owning, the scan starts just past the owner so the owner itself is never re-picked.
    assign scan_start = (state == OWN) ? owner_succ : rr_ptr;
    assign owner_req  = req[owner_q];
    assign hold_done  = (hold_cnt == HOLD_MAX);

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_rr (
        .req      (req),
        .start    (scan_start),
        .excl_en  (state == OWN),
        .excl_idx (owner_q),
        .found    (pick_found),
        .idx      (pick_idx)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            owner_q  <= '0;
            rr_ptr   <= '0;
            hold_cnt <= '0;
            disp_reg <= '0;
            shown    <= 1'b0;
        end else begin
            state    <= state_nx;
            owner_q  <= owner_nx;
            rr_ptr   <= rr_ptr_nx;
            hold_cnt <= hold_cnt_nx;
            disp_reg <= disp_nx;
            shown    <= shown_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        owner_nx    = owner_q;
        rr_ptr_nx   = rr_ptr;
        hold_cnt_nx = hold_cnt;
        disp_nx     = disp_reg;
        shown_nx    = shown;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nx    = OWN;
                    owner_nx    = pick_idx;
                    hold_cnt_nx = '0;
                    disp_nx     = value[int'(pick_idx)*DW +: DW];
                    shown_nx    = 1'b1;
                end
            end
            OWN: begin
                if ((!owner_req || hold_done) && pick_found) begin
                    owner_nx    = pick_idx;
                    rr_ptr_nx   = owner_succ;
                    hold_cnt_nx = '0;
                    disp_nx     = value[int'(pick_idx)*DW +: DW];
                end else if (!owner_req) begin
                    // Release with nobody waiting: display freezes on the last owned value.
                    state_nx    = IDLE;
                    hold_cnt_nx = '0;
                end else begin
                    disp_nx = value[int'(owner_q)*DW +: DW];
                    if (!hold_done) begin
                        hold_cnt_nx = hold_cnt + CW'(1);
                    end
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_comb begin
        grant = '0;
        if (state == OWN) begin
            grant[owner_q] = 1'b1;
        end
        owner_valid = (state == OWN);
        owner_id    = owner_q;
    end

    for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_digit
        logic lead_blank;
`ifdef HEX_ZERO_BLANK_EN
        if (d == 0) begin : g_lsd
            assign lead_blank = 1'b0;
        end else begin : g_upper
            assign lead_blank = ~|disp_reg[DW-1:4*d];
        end
`else
        assign lead_blank = 1'b0;
`endif
        assign hex_out[d*7 +: 7] = (!shown || lead_blank) ? SEG_BLANK
                                                          : hex_to_seg(disp_reg[4*d +: 4]);
    end

endmodule
